regfile_arbiter: RTL

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_pkg.sv | 16 +
 rtl/regfile_arbiter_rr_pick.sv | 25 ++
 rtl/regfile_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_pkg.sv
// regfile_arbiter_pkg: shared types and sizes for the register-file arbiter.
// Holds the FSM state encoding and the register-file geometry.
package regfile_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B,
    SCRUB
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// rr_pick: two-way round-robin winner.
// last = 1 means B was served most recently, so A wins a tie.
module rr_pick (
  input  logic a_req,
  input  logic b_req,
  input  logic last,
  output logic pick_a,
  output logic pick_b
);

  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    unique case (1'b1)
      (a_req && b_req): begin
        pick_a = last;
        pick_b = !last;
      end
      (a_req && !b_req): pick_a = 1'b1;
      (!a_req && b_req): pick_b = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester register-file port arbiter with burst fairness.
// Optional 8-cycle register scrub built when REGFILE_ARBITER_SCRUB_EN is defined.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_wr,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] a_dr,
  input  logic [ADDR_W-1:0] a_sr1,
  input  logic [ADDR_W-1:0] a_sr2,
  input  logic [ADDR_W-1:0] b_dr,
  input  logic [ADDR_W-1:0] b_sr1,
  input  logic [ADDR_W-1:0] b_sr2,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic              scrub_start,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic [DATA_W-1:0] Buss,
  output logic [ADDR_W-1:0] DR,
  output logic [ADDR_W-1:0] SR1,
  output logic [ADDR_W-1:0] SR2,
  output logic              regWE,
  output logic              scrub_busy
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  state_t        state;
  state_t        state_nx;
  logic          last;
  logic [BW-1:0] burst;
  logic          pick_a;
  logic          pick_b;
  logic          scrub_go;

  rr_pick u_pick (
    .a_req  (a_req),
    .b_req  (b_req),
    .last   (last),
    .pick_a (pick_a),
    .pick_b (pick_b)
  );

`ifdef REGFILE_ARBITER_SCRUB_EN
  localparam logic [ADDR_W-1:0] SCRUB_LAST = ADDR_W'(NREG - 1);

  logic              pending;
  logic              scrub_done;
  logic [ADDR_W-1:0] scrub_cnt;

  assign scrub_go   = pending;
  assign scrub_done = (scrub_cnt == SCRUB_LAST);

  // A pulse during a grant is parked until IDLE; extra pulses are absorbed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      scrub_cnt <= '0;
    end else begin
      if (state == IDLE && state_nx == SCRUB)
        pending <= 1'b0;
      else if (scrub_start && state != SCRUB)
        pending <= 1'b1;
      if (state == SCRUB)
        scrub_cnt <= scrub_cnt + 1'b1;
      else
        scrub_cnt <= '0;
    end
  end
`else
  logic unused_scrub;

  assign unused_scrub = scrub_start;
  assign scrub_go     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (scrub_go)
          state_nx = SCRUB;
        else if (pick_a)
          state_nx = GNT_A;
        else if (pick_b)
          state_nx = GNT_B;
      end
      GNT_A: begin
        if (!a_req)
          state_nx = b_req ? GNT_B : IDLE;
        else if (b_req && burst == BURST_LAST)
          state_nx = GNT_B;
      end
      GNT_B: begin
        if (!b_req)
          state_nx = a_req ? GNT_A : IDLE;
        else if (a_req && burst == BURST_LAST)
          state_nx = GNT_A;
      end
`ifdef REGFILE_ARBITER_SCRUB_EN
      SCRUB: begin
        if (scrub_done)
          state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Burst count saturates so a late waiter is served on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      burst <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        burst <= '0;
      else if ((state == GNT_A || state == GNT_B) && burst != BURST_LAST)
        burst <= burst + BW'(1);
      if (state_nx != state && state_nx == GNT_A)
        last <= 1'b0;
      else if (state_nx != state && state_nx == GNT_B)
        last <= 1'b1;
    end
  end

  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    DR         = '0;
    SR1        = '0;
    SR2        = '0;
    Buss       = '0;
    regWE      = 1'b0;
    scrub_busy = 1'b0;
    if (!reset) begin
      unique case (state)
        GNT_A: begin
          a_gnt = 1'b1;
          DR    = a_dr;
          SR1   = a_sr1;
          SR2   = a_sr2;
          Buss  = a_data;
          regWE = a_req & a_wr;
        end
        GNT_B: begin
          b_gnt = 1'b1;
          DR    = b_dr;
          SR1   = b_sr1;
          SR2   = b_sr2;
          Buss  = b_data;
          regWE = b_req & b_wr;
        end
`ifdef REGFILE_ARBITER_SCRUB_EN
        SCRUB: begin
          DR         = scrub_cnt;
          regWE      = 1'b1;
          scrub_busy = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
